frame_sequencer: RTL

Per-frame controller for the graphics datapath. On each accepted frame tick it latches the aircraft pose. It then runs four stages in order: an MVP-update pass on the vertex pipe, a vertex-transform pass over `vertex_count` vertices, a rasterizer pass, and a framebuffer swap handshake. It sits between the flight-state registers and the vertex pipe, rasterizer and display controller. It owns all start/done sequencing, overrun accounting and hang detection.

---
 rtl/graphics_pkg.sv | 35 +++
 rtl/frame_sequencer_stage_handshake.sv | 65 ++++++
 rtl/frame_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/graphics_pkg.sv
// Shared types for the graphics datapath control: frame sequencer states,
// per-stage handshake phases and the default stage timeout.
package graphics_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 2_000_000;

  // Each stage's ISSUE/WAIT_LO/WAIT_HI states are consecutive so a stage
  // state can be formed from its ISSUE state plus the handshake phase.
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    MVP_ISSUE   = 4'd1,
    MVP_WAIT_LO = 4'd2,
    MVP_WAIT_HI = 4'd3,
    VTX_ISSUE   = 4'd4,
    VTX_WAIT_LO = 4'd5,
    VTX_WAIT_HI = 4'd6,
    RAS_ISSUE   = 4'd7,
    RAS_WAIT_LO = 4'd8,
    RAS_WAIT_HI = 4'd9,
    SWAP        = 4'd10
  } frame_seq_state_t;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_ISSUE   = 2'd1,
    HS_WAIT_LO = 2'd2,
    HS_WAIT_HI = 2'd3
  } hs_phase_t;

  function automatic frame_seq_state_t stage_state(frame_seq_state_t issue_state,
                                                   hs_phase_t ph);
    return frame_seq_state_t'(4'(issue_state) + {2'b00, ph} - 4'd1);
  endfunction

endpackage

// File: rtl/frame_sequencer_stage_handshake.sv
// One start/done stage: issue a start pulse, wait for done to drop (start
// acknowledged), then wait for done to rise again (work finished).
module stage_handshake
  import graphics_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      go,
  input  logic      done_i,
  output logic      start_o,
  output logic      finished,
  output logic      timed_out,
  output hs_phase_t phase_nxt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Protocol: done_i is a level that is high while the target is idle.
  // start_o is a one-cycle pulse issued only while done_i is high; the target
  // acknowledges by dropping done_i and completes by raising it again.
  hs_phase_t        phase;
  logic [CNT_W-1:0] cnt;
  logic             start_nxt;

  always_comb begin
    phase_nxt = phase;
    start_nxt = 1'b0;
    finished  = 1'b0;
    timed_out = 1'b0;
    case (phase)
      HS_IDLE:    if (go) phase_nxt = HS_ISSUE;
      HS_ISSUE:   if (done_i) begin
                    phase_nxt = HS_WAIT_LO;
                    start_nxt = 1'b1;
                  end
      HS_WAIT_LO: if (!done_i) phase_nxt = HS_WAIT_HI;
      HS_WAIT_HI: if (done_i) begin
                    phase_nxt = HS_IDLE;
                    finished  = 1'b1;
                  end
    endcase
    // cnt holds the number of stage cycles already spent before this one
    if (phase != HS_IDLE && !finished && cnt == LAST) begin
      timed_out = 1'b1;
      start_nxt = 1'b0;
      phase_nxt = HS_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= HS_IDLE;
      start_o <= 1'b0;
      cnt     <= '0;
    end else begin
      phase   <= phase_nxt;
      start_o <= start_nxt;
      cnt     <= (phase == HS_IDLE || phase_nxt == HS_IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: latches the pose on an accepted tick, then sequences
// MVP update, vertex transform, rasterize and buffer swap with hang detection.
module frame_sequencer
  import graphics_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int          FRAME_CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic [31:0]            roll,
  input  logic [31:0]            pitch,
  input  logic [31:0]            yaw,
  input  logic [31:0]            x,
  input  logic [31:0]            y,
  input  logic [31:0]            z,
  input  logic [31:0]            vertex_count,
  output logic                   vp_start,
  output logic                   vp_update_mvp,
  output logic [31:0]            vp_roll,
  output logic [31:0]            vp_pitch,
  output logic [31:0]            vp_yaw,
  output logic [31:0]            vp_x,
  output logic [31:0]            vp_y,
  output logic [31:0]            vp_z,
  output logic [31:0]            vp_count,
  input  logic                   vp_done,
  output logic                   rs_start,
  input  logic                   rs_done,
  output logic                   swap_req,
  input  logic                   swap_ack,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [15:0]            overrun_count,
  output logic                   timeout_err,
  output frame_seq_state_t       state_dbg
);

  frame_seq_state_t state, next_state;
  logic      mvp_go, vtx_go, ras_go;
  logic      mvp_start, vtx_start;
  logic      mvp_fin, vtx_fin, ras_fin;
  logic      mvp_to, vtx_to, ras_to;
  hs_phase_t mvp_ph_nxt, vtx_ph_nxt, ras_ph_nxt;
  logic      accept, set_timeout, frame_done;

  stage_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mvp (
    .clock(clock), .reset(reset), .go(mvp_go), .done_i(vp_done), .start_o(mvp_start),
    .finished(mvp_fin), .timed_out(mvp_to), .phase_nxt(mvp_ph_nxt));

  stage_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_vtx (
    .clock(clock), .reset(reset), .go(vtx_go), .done_i(vp_done), .start_o(vtx_start),
    .finished(vtx_fin), .timed_out(vtx_to), .phase_nxt(vtx_ph_nxt));

  stage_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ras (
    .clock(clock), .reset(reset), .go(ras_go), .done_i(rs_done), .start_o(rs_start),
    .finished(ras_fin), .timed_out(ras_to), .phase_nxt(ras_ph_nxt));

  // MVP and VTX share the vertex pipe and are never active together
  assign vp_start  = mvp_start | vtx_start;
  assign state_dbg = state;

  always_comb begin
    next_state  = state;
    mvp_go      = 1'b0;
    vtx_go      = 1'b0;
    ras_go      = 1'b0;
    accept      = 1'b0;
    set_timeout = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: if (frame_tick && enable) begin
        accept     = 1'b1;
        mvp_go     = 1'b1;
        next_state = MVP_ISSUE;
      end
      MVP_ISSUE, MVP_WAIT_LO, MVP_WAIT_HI: begin
        if (mvp_to) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end else if (mvp_fin) begin
          // a zero-count transform pass would never finish, so skip to swap
          if (vp_count == 32'd0) next_state = SWAP;
          else begin
            vtx_go     = 1'b1;
            next_state = VTX_ISSUE;
          end
        end else next_state = stage_state(MVP_ISSUE, mvp_ph_nxt);
      end
      VTX_ISSUE, VTX_WAIT_LO, VTX_WAIT_HI: begin
        if (vtx_to) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end else if (vtx_fin) begin
          ras_go     = 1'b1;
          next_state = RAS_ISSUE;
        end else next_state = stage_state(VTX_ISSUE, vtx_ph_nxt);
      end
      RAS_ISSUE, RAS_WAIT_LO, RAS_WAIT_HI: begin
        if (ras_to) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end else if (ras_fin) next_state = SWAP;
        else next_state = stage_state(RAS_ISSUE, ras_ph_nxt);
      end
      SWAP: if (swap_ack) begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      vp_update_mvp <= 1'b0;
      swap_req      <= 1'b0;
      vp_roll       <= '0;
      vp_pitch      <= '0;
      vp_yaw        <= '0;
      vp_x          <= '0;
      vp_y          <= '0;
      vp_z          <= '0;
      vp_count      <= '0;
      frame_count   <= '0;
      overrun_count <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= next_state;
      busy          <= (next_state != IDLE);
      vp_update_mvp <= (next_state inside {MVP_ISSUE, MVP_WAIT_LO, MVP_WAIT_HI});
      swap_req      <= (next_state == SWAP);
      if (accept) begin
        vp_roll  <= roll;
        vp_pitch <= pitch;
        vp_yaw   <= yaw;
        vp_x     <= x;
        vp_y     <= y;
        vp_z     <= z;
        vp_count <= vertex_count;
      end
      if (frame_done) frame_count <= frame_count + FRAME_CNT_W'(1);
      if (frame_tick && busy && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
      if (set_timeout) timeout_err <= 1'b1;
    end
  end

endmodule
